// File: rtl/ram_sp_arb2.sv
// Round-robin arbiter/sequencer giving two valid/ready requesters access to one async-read single-port RAM.
// Define RAM_ARB_FIXED_PRIO_EN to make requester 0 always win ties (no rotation pointer).
module ram_sp_arb2 #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [AWIDTH-1:0] req0_addr,
    input  logic [DWIDTH-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DWIDTH-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [AWIDTH-1:0] req1_addr,
    input  logic [DWIDTH-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DWIDTH-1:0] req1_rdata,
    output logic              ram_cs,
    output logic              ram_oe,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_address,
    inout  wire  [DWIDTH-1:0] ram_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } state_t;

    state_t              state_reg;
    logic                id_reg;
    logic [DWIDTH-1:0]   wdata_reg;
    logic                ram_cs_reg;
    logic                ram_oe_reg;
    logic                ram_we_reg;
    logic [AWIDTH-1:0]   ram_address_reg;

    logic [1:0]          valid;
    logic [1:0]          grant;
    logic [1:0]          ready;
    logic                accept;
    logic                sel_id;
    logic                sel_we;
    logic [AWIDTH-1:0]   sel_addr;
    logic [DWIDTH-1:0]   sel_wdata;
    logic [1:0]          rvalid_all;
    logic [2*DWIDTH-1:0] rdata_all;
    logic                read_return;

    assign valid = {req1_valid, req0_valid};

`ifdef RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant    = 2'b00;
        grant[0] = valid[0];
        grant[1] = valid[1] && !valid[0];
    end
`else
    logic last_reg;

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_reg ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else if (accept) begin
            last_reg <= sel_id;
        end
    end
`endif

    assign ready      = (state_reg == IDLE && !rst) ? grant : 2'b00;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign accept     = |ready;
    assign sel_id     = ready[1];
    assign sel_we     = sel_id ? req1_we    : req0_we;
    assign sel_addr   = sel_id ? req1_addr  : req0_addr;
    assign sel_wdata  = sel_id ? req1_wdata : req0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            id_reg          <= 1'b0;
            wdata_reg       <= '0;
            ram_cs_reg      <= 1'b0;
            ram_oe_reg      <= 1'b0;
            ram_we_reg      <= 1'b0;
            ram_address_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        id_reg          <= sel_id;
                        wdata_reg       <= sel_wdata;
                        ram_address_reg <= sel_addr;
                        ram_cs_reg      <= 1'b1;
                        ram_we_reg      <= sel_we;
                        ram_oe_reg      <= !sel_we;
                        state_reg       <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_cs_reg <= 1'b0;
                    ram_oe_reg <= 1'b0;
                    ram_we_reg <= 1'b0;
                    state_reg  <= TURN;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ram_cs      = ram_cs_reg;
    assign ram_oe      = ram_oe_reg;
    assign ram_we      = ram_we_reg;
    assign ram_address = ram_address_reg;

    // Bus is only driven during a write access, when oe is guaranteed low.
    assign ram_data    = (state_reg == ACCESS && ram_we_reg) ? wdata_reg : {DWIDTH{1'bz}};
    assign read_return = (state_reg == ACCESS) && !ram_we_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            logic              rvalid_reg;
            logic [DWIDTH-1:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= read_return && (id_reg == 1'(gi));
                    if (read_return && (id_reg == 1'(gi))) begin
                        rdata_reg <= ram_data;
                    end
                end
            end

            // A read whose return edge coincides with reset is dropped.
            assign rvalid_all[gi]                    = rvalid_reg && !rst;
            assign rdata_all[gi*DWIDTH +: DWIDTH]    = rdata_reg;
        end
    endgenerate

    assign req0_rvalid = rvalid_all[0];
    assign req1_rvalid = rvalid_all[1];
    assign req0_rdata  = rdata_all[DWIDTH-1:0];
    assign req1_rdata  = rdata_all[2*DWIDTH-1:DWIDTH];

endmodule

// File: tb/tb_ram_sp_arb2.sv
// Bench for ram_sp_arb2: async-read RAM model on the shared bus, transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_ram_sp_arb2;
    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_we, req0_ready, req0_rvalid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic          req1_valid, req1_we, req1_ready, req1_rvalid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic          ram_cs, ram_oe, ram_we;
    logic [AW-1:0] ram_address;
    wire  [DW-1:0] ram_data;

    ram_sp_arb2 #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we), .ram_address(ram_address),
        .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // Environment RAM: async read, write committed on the clock edge.
    logic [DW-1:0] ram_mem [256];
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_mem[ram_address] : {DW{1'bz}};
    always @(posedge clk) if (ram_cs && ram_we) ram_mem[ram_address] <= ram_data;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = free, 1 = access cycle, 2 = turnaround cycle.
    int            m_phase = 0;
    bit            m_last  = 1'b1;
    bit            m_id, m_we;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_mem [256];
    logic [DW-1:0] m_rdata [2];
    int            cyc = 0;
    int            acc_id[$];
    int            acc_cyc[$];

    function automatic int pick(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            return 0;
`else
            return m_last ? 0 : 1;
`endif
        end
        return v0 ? 0 : 1;
    endfunction

    always @(posedge clk) begin
        int w;
        cyc++;
        if (m_phase == 1 && m_we) m_mem[m_addr] = m_wdata;
        if (rst) begin
            m_phase = 0; m_last = 1'b1; m_addr = '0;
            m_rdata[0] = '0; m_rdata[1] = '0;
        end else if (m_phase == 0) begin
            if (req0_valid || req1_valid) begin
                w       = pick(req0_valid, req1_valid);
                m_id    = (w == 1);
                m_we    = m_id ? req1_we    : req0_we;
                m_addr  = m_id ? req1_addr  : req0_addr;
                m_wdata = m_id ? req1_wdata : req0_wdata;
                m_last  = m_id;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!m_we) m_rdata[m_id] = m_mem[m_addr];
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            bit any;
            int w;
            @(negedge clk);
            any = req0_valid || req1_valid;
            w   = pick(req0_valid, req1_valid);
            chk("req0_ready", req0_ready, !rst && m_phase == 0 && any && w == 0);
            chk("req1_ready", req1_ready, !rst && m_phase == 0 && any && w == 1);
            chk("ram_cs", ram_cs, m_phase == 1);
            chk("ram_we", ram_we, m_phase == 1 && m_we);
            chk("ram_oe", ram_oe, m_phase == 1 && !m_we);
            chk("ram_address", ram_address, m_addr);
            chk("req0_rvalid", req0_rvalid, !rst && m_phase == 2 && !m_we && !m_id);
            chk("req1_rvalid", req1_rvalid, !rst && m_phase == 2 && !m_we && m_id);
            chk("req0_rdata", req0_rdata, m_rdata[0]);
            chk("req1_rdata", req1_rdata, m_rdata[1]);
            if (m_phase == 1 && m_we)  chk("bus_wdata", ram_data, m_wdata);
            if (m_phase == 1 && !m_we) chk("bus_rdata", ram_data, m_mem[m_addr]);
            if (ram_oe && ram_we) chk("oe_we_overlap", 1, 0);
            if (!rst && req0_valid && req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
            if (!rst && req1_valid && req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(cyc); end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns #1 after its accept edge with valid dropped.
    task automatic do_req(input bit id, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bit got = 1'b0;
        if (id) begin req1_valid = 1; req1_we = we; req1_addr = addr; req1_wdata = wd; end
        else    begin req0_valid = 1; req0_we = we; req0_addr = addr; req0_wdata = wd; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
            tick();
        end
        if (!got) chk("accept_timeout", 0, 1);
        req0_valid = 0;
        req1_valid = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'(i) ^ 8'h5A;
            m_mem[i]   = 8'(i) ^ 8'h5A;
        end
        m_rdata[0] = '0; m_rdata[1] = '0;
        rst = 1;
        req0_valid = 1; req0_we = 0; req0_addr = 8'h33; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_addr = 0;     req1_wdata = 0;

        // 1: reset, ready held low even with a valid request
        tick(); tick();
        chk("reset_ready0", req0_ready, 0);
        chk("reset_cs", ram_cs, 0);
        chk("reset_addr", ram_address, 0);
        req0_valid = 0;
        rst = 0;
        tick();

        // 2: write then read back the same address
        do_req(0, 1, 8'h10, 8'hA5);
        tick(); tick();
        do_req(0, 0, 8'h10, 8'h00);
        tick();
        chk("t2_rvalid", req0_rvalid, 1);
        chk("t2_rdata", req0_rdata, 8'hA5);
        tick();
        chk("t2_rvalid_pulse", req0_rvalid, 0);

        // 5: write interrupted by reset in its access cycle still lands
        do_req(1, 1, 8'h20, 8'h3C);
        rst = 1;
        tick();
        rst = 0;
        do_req(0, 0, 8'h20, 8'h00);
        tick();
        chk("t5_rdata", req0_rdata, 8'h3C);
        tick();

        // 6: read dropped by reset during turnaround
        do_req(1, 0, 8'h02, 8'h00);
        tick();
        rst = 1;
        #1;
        chk("t6_rvalid_drop", req1_rvalid, 0);
        tick();
        rst = 0;
        tick();
        chk("t6_rdata_cleared", req1_rdata, 0);

        // 3/4: both requesters streaming reads
        rst = 1; tick(); rst = 0;
        acc_id.delete(); acc_cyc.delete();
        req0_valid = 1; req0_we = 0; req0_addr = 8'h01;
        req1_valid = 1; req1_we = 0; req1_addr = 8'h02;
        for (int i = 0; i < 40 && acc_id.size() < 4; i++) tick();
        req0_valid = 0; req1_valid = 0;
        if (acc_id.size() < 4) chk("t3_accept_count", acc_id.size(), 4);
        else begin
            for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                chk("t4_grant_id", acc_id[i], 0);
`else
                chk("t3_grant_id", acc_id[i], i % 2);
`endif
                if (i > 0) chk("t3_accept_gap", acc_cyc[i] - acc_cyc[i-1], 3);
            end
        end
        tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
